// File: rtl/ssid_hcm_dispatcher_pkg.sv
// Shared sizing defaults and FSM encoding for the SSID-to-HCM dispatcher.
package ssid_hcm_dispatcher_pkg;

    localparam int SSIDBITS         = 16;
    localparam int ROWINDEXBITS_HCM = 16;
    localparam int NROWS_HCM        = 65536;
    localparam int MAXSSIDS_EVENT   = 64;

    typedef enum logic [2:0] {
        INIT_SWEEP,
        RUN,
        DRAIN,
        CLEAR_LIST,
        CLEAR_SWEEP
    } state_t;

endpackage

// File: rtl/ssid_seen_bitmap.sv
// 1-bit per row "seen" bitmap, simple dual-port; registered read (1 cycle), read holds when rd_en is low.
// No bypass between ports: same-cycle read/write returns the old bit, the parent forwards.
module ssid_seen_bitmap #(
    parameter int ADDRBITS = 16,
    parameter int DEPTH    = 65536
) (
    input  logic                clk,
    input  logic                rd_en,
    input  logic [ADDRBITS-1:0] rd_addr,
    output logic                rd_dat,
    input  logic                wr_en,
    input  logic [ADDRBITS-1:0] wr_addr,
    input  logic                wr_dat
);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ssid_hcm_dispatcher.sv
// Marks each SSID of an event as first-seen/repeat and drives HCM writes; 2-cycle latency, 1 SSID/cycle.
// Backpressure: a held stage-2 write (hcmBusy or !hcmWriteReady) freezes the whole pipeline and drops ssidReady.
module ssid_hcm_dispatcher #(
    parameter int SSIDBITS         = ssid_hcm_dispatcher_pkg::SSIDBITS,
    parameter int ROWINDEXBITS_HCM = ssid_hcm_dispatcher_pkg::ROWINDEXBITS_HCM,
    parameter int NROWS_HCM        = ssid_hcm_dispatcher_pkg::NROWS_HCM,
    parameter int MAXSSIDS_EVENT   = ssid_hcm_dispatcher_pkg::MAXSSIDS_EVENT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SSIDBITS-1:0]         ssidIn,
    input  logic                        ssidValid,
    input  logic                        ssidLast,
    output logic                        ssidReady,
    input  logic                        hcmBusy,
    input  logic                        hcmWriteReady,
    output logic                        writeRow,
    output logic [ROWINDEXBITS_HCM-1:0] inputRowToWrite,
    output logic                        SSIDIsNew,
    output logic                        eventDone,
    output logic                        overflow,
    output logic                        busy
);

    import ssid_hcm_dispatcher_pkg::*;

    localparam int CW = $clog2(MAXSSIDS_EVENT + 1);
    localparam int IW = (MAXSSIDS_EVENT > 1) ? $clog2(MAXSSIDS_EVENT) : 1;
    localparam logic [ROWINDEXBITS_HCM-1:0] LAST_ROW = ROWINDEXBITS_HCM'(NROWS_HCM - 1);

    state_t                      state;
    state_t                      state_nxt;
    logic                        s1_vld;
    logic                        s2_vld;
    logic                        s2_new;
    logic [SSIDBITS-1:0]         s1_ssid;
    logic [SSIDBITS-1:0]         s2_ssid;
    logic                        seen;
    logic                        stall;
    logic                        accept;
    logic                        is_new;
    logic [ROWINDEXBITS_HCM-1:0] sweep_cnt;
    logic                        sweep_done;
    logic [CW-1:0]               list_cnt;
    logic [ROWINDEXBITS_HCM-1:0] list_mem [MAXSSIDS_EVENT];
    logic [ROWINDEXBITS_HCM-1:0] list_top;
    logic                        list_full;
    logic                        list_empty;
    logic                        push;
    logic                        pop;
    logic                        clear_done;
    logic                        ovf_q;
    logic                        done_q;
    logic                        wr_en;
    logic                        wr_dat;
    logic [ROWINDEXBITS_HCM-1:0] wr_addr;

    assign stall      = s2_vld && (hcmBusy || !hcmWriteReady);
    assign ssidReady  = (state == RUN) && !stall;
    assign accept     = ssidValid && ssidReady;
    // The bitmap write of the SSID now in stage 2 lands too late for this read.
    assign is_new     = !seen && !(s2_vld && (s2_ssid == s1_ssid));
    assign push       = s1_vld && !stall && is_new;
    assign list_full  = (list_cnt == CW'(MAXSSIDS_EVENT));
    assign list_empty = (list_cnt == '0);
    assign list_top   = list_mem[IW'(list_cnt - CW'(1))];
    assign sweep_done = (sweep_cnt == LAST_ROW);

    assign writeRow        = s2_vld && !stall;
    assign inputRowToWrite = s2_ssid;
    assign SSIDIsNew       = s2_new;
    assign eventDone       = done_q;
    assign overflow        = ovf_q;
    assign busy            = (state != RUN);

    ssid_seen_bitmap #(
        .ADDRBITS (ROWINDEXBITS_HCM),
        .DEPTH    (NROWS_HCM)
    ) u_bitmap (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (ssidIn),
        .rd_dat  (seen),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat)
    );

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        clear_done = 1'b0;
        wr_en      = 1'b0;
        wr_dat     = 1'b0;
        wr_addr    = s1_ssid;
        case (state)
            INIT_SWEEP: begin
                wr_en   = 1'b1;
                wr_addr = sweep_cnt;
                if (sweep_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                wr_en  = s1_vld && !stall;
                wr_dat = 1'b1;
                if (accept && ssidLast) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                wr_en  = s1_vld && !stall;
                wr_dat = 1'b1;
                if (!s1_vld && !s2_vld) begin
                    state_nxt = ovf_q ? CLEAR_SWEEP : CLEAR_LIST;
                end
            end
            CLEAR_LIST: begin
                pop     = !list_empty;
                wr_en   = pop;
                wr_addr = list_top;
                // Finishing on the last pop keeps the clear to exactly N cycles.
                if (list_cnt <= CW'(1)) begin
                    clear_done = 1'b1;
                    state_nxt  = RUN;
                end
            end
            CLEAR_SWEEP: begin
                wr_en   = 1'b1;
                wr_addr = sweep_cnt;
                if (sweep_done) begin
                    clear_done = 1'b1;
                    state_nxt  = RUN;
                end
            end
            default: state_nxt = INIT_SWEEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= INIT_SWEEP;
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            s1_ssid   <= '0;
            s2_ssid   <= '0;
            s2_new    <= 1'b0;
            sweep_cnt <= '0;
            list_cnt  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= clear_done;
            if (!stall) begin
                s1_vld <= accept;
                if (accept) begin
                    s1_ssid <= ssidIn;
                end
                s2_vld <= s1_vld;
                s2_new <= s1_vld && is_new;
                if (s1_vld) begin
                    s2_ssid <= s1_ssid;
                end
            end
            if ((state == INIT_SWEEP) || (state == CLEAR_SWEEP)) begin
                sweep_cnt <= sweep_done ? '0 : sweep_cnt + ROWINDEXBITS_HCM'(1);
            end
            if (push) begin
                if (list_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    list_cnt <= list_cnt + CW'(1);
                end
            end else if (pop) begin
                list_cnt <= list_cnt - CW'(1);
            end
            if (clear_done) begin
                ovf_q <= 1'b0;
                if (state == CLEAR_SWEEP) begin
                    list_cnt <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !list_full) begin
            list_mem[IW'(list_cnt)] <= s1_ssid;
        end
    end

endmodule
